// File: rtl/branch_map_builder_if.sv
// Handshake bundle between the itype detector / packet emitter and the
// branch map builder. Signal suffixes are from the builder's point of view.
interface branch_map_builder_if #(
   parameter int N_BRANCH = 31
);
   localparam int CNT_W = $clog2(N_BRANCH + 1);

   logic             itype_valid_i;
   logic [2:0]       itype_i;
   logic             itype_ready_o;
   logic             flush_i;
   logic             map_valid_o;
   logic             map_ready_i;
   logic [30:0]      branch_map_o;
   logic [CNT_W-1:0] branch_count_o;
   logic [1:0]       reason_o;
   logic [2:0]       event_itype_o;

   // builder side
   modport slave (
      input  itype_valid_i, itype_i, flush_i, map_ready_i,
      output itype_ready_o, map_valid_o, branch_map_o, branch_count_o,
             reason_o, event_itype_o
   );

   // itype source / packet emitter side
   modport master (
      output itype_valid_i, itype_i, flush_i, map_ready_i,
      input  itype_ready_o, map_valid_o, branch_map_o, branch_count_o,
             reason_o, event_itype_o
   );
endinterface

// File: rtl/branch_map_builder.sv
// Accumulates branch outcomes from the retired itype stream into an E-Trace
// branch map and hands out one record per full map, discontinuity or flush.
// The output register doubles as the single-entry record buffer; while it
// holds an unaccepted record the itype stream is stalled.
module branch_map_builder #(
   parameter int N_BRANCH = 31
) (
   input  logic                clk_i,
   input  logic                reset_i,
   branch_map_builder_if.slave bus
);
   localparam int CNT_W = $clog2(N_BRANCH + 1);

   typedef enum logic {
      S_EMPTY    = 1'b0,
      S_FULL_OUT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [30:0]      acc_map_q, acc_map_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [30:0]      out_map_q, out_map_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [1:0]       out_reason_q, out_reason_d;
   logic [2:0]       out_evt_q, out_evt_d;

   logic             ready;
   logic             take;
   logic             is_br;
   logic             is_dis;
   logic             full_hit;
   logic             flush_hit;
   logic [30:0]      acc_map_nxt;
   logic [CNT_W-1:0] acc_cnt_nxt;

   // Input can move whenever the record slot is free or draining this cycle.
   assign ready = (state_q == S_EMPTY) | bus.map_ready_i;

   // Next-state: fold in this cycle's branch, then decide whether to emit.
   always_comb begin
      take   = bus.itype_valid_i & ready;
      is_br  = take & ((bus.itype_i == 3'd4) | (bus.itype_i == 3'd5));
      is_dis = take & ((bus.itype_i == 3'd1) | (bus.itype_i == 3'd2) |
                       (bus.itype_i == 3'd3) | (bus.itype_i == 3'd6));

      // Accumulator view after this cycle's branch (bit = 1 for not-taken).
      acc_map_nxt = acc_map_q;
      acc_cnt_nxt = acc_cnt_q;
      if (is_br) begin
         acc_map_nxt = acc_map_q | (31'(bus.itype_i == 3'd4) << acc_cnt_q);
         acc_cnt_nxt = acc_cnt_q + CNT_W'(1);
      end

      full_hit  = is_br & (acc_cnt_nxt == CNT_W'(N_BRANCH));
      // flush only counts if the map is non-empty after this cycle's branch
      flush_hit = ready & bus.flush_i & (acc_cnt_nxt != '0);

      state_d      = state_q;
      acc_map_d    = acc_map_nxt;
      acc_cnt_d    = acc_cnt_nxt;
      out_map_d    = out_map_q;
      out_cnt_d    = out_cnt_q;
      out_reason_d = out_reason_q;
      out_evt_d    = out_evt_q;

      if (state_q == S_FULL_OUT && bus.map_ready_i)
         state_d = S_EMPTY;

      // Emission reloads the slot (even while it drains) and empties the map.
      // FULL outranks DISCON, which outranks FLUSH.
      if (full_hit | is_dis | flush_hit) begin
         state_d   = S_FULL_OUT;
         out_map_d = acc_map_nxt;
         out_cnt_d = acc_cnt_nxt;
         acc_map_d = '0;
         acc_cnt_d = '0;
         if (full_hit) begin
            out_reason_d = 2'd0;
            out_evt_d    = 3'd0;
         end else if (is_dis) begin
            out_reason_d = 2'd1;
            out_evt_d    = bus.itype_i;
         end else begin
            out_reason_d = 2'd2;
            out_evt_d    = 3'd0;
         end
      end
   end

   // State and record registers; reset discards any pending record and map.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_EMPTY;
         acc_map_q    <= '0;
         acc_cnt_q    <= '0;
         out_map_q    <= '0;
         out_cnt_q    <= '0;
         out_reason_q <= '0;
         out_evt_q    <= '0;
      end else begin
         state_q      <= state_d;
         acc_map_q    <= acc_map_d;
         acc_cnt_q    <= acc_cnt_d;
         out_map_q    <= out_map_d;
         out_cnt_q    <= out_cnt_d;
         out_reason_q <= out_reason_d;
         out_evt_q    <= out_evt_d;
      end
   end

   assign bus.itype_ready_o  = ready;
   assign bus.map_valid_o    = (state_q == S_FULL_OUT);
   assign bus.branch_map_o   = out_map_q;
   assign bus.branch_count_o = out_cnt_q;
   assign bus.reason_o       = out_reason_q;
   assign bus.event_itype_o  = out_evt_q;

endmodule

// File: tb/tb_branch_map_builder.sv
// Bench for branch_map_builder: a 31-branch and a 4-branch instance share
// one stimulus stream; each is compared every cycle with a record-level
// model, plus directed checks on the scenarios of interest.
module tb_branch_map_builder;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       itype_valid = 1'b0;
   logic [2:0] itype = 3'd0;
   logic       flush = 1'b0;
   logic       map_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model; index 0 = N_BRANCH 31, index 1 = N_BRANCH 4
   int m_n[2] = '{31, 4};
   bit m_vld[2];
   int m_map[2];
   int m_cnt[2];
   int m_rsn[2];
   int m_evt[2];
   bit acc_bits[2][32];
   int acc_n[2];

   always #5 clk = ~clk;

   branch_map_builder_if #(.N_BRANCH(31)) bus31();
   branch_map_builder_if #(.N_BRANCH(4))  bus4();

   assign bus31.itype_valid_i = itype_valid;
   assign bus31.itype_i       = itype;
   assign bus31.flush_i       = flush;
   assign bus31.map_ready_i   = map_ready;
   assign bus4.itype_valid_i  = itype_valid;
   assign bus4.itype_i        = itype;
   assign bus4.flush_i        = flush;
   assign bus4.map_ready_i    = map_ready;

   branch_map_builder #(.N_BRANCH(31)) u31 (.clk_i(clk), .reset_i(reset), .bus(bus31));
   branch_map_builder #(.N_BRANCH(4))  u4  (.clk_i(clk), .reset_i(reset), .bus(bus4));

   function automatic void m_clear(int i);
      m_vld[i] = 1'b0;
      m_map[i] = 0;
      m_cnt[i] = 0;
      m_rsn[i] = 0;
      m_evt[i] = 0;
      acc_n[i] = 0;
   endfunction

   function automatic void m_emit(int i, int rsn, int evt);
      m_map[i] = 0;
      for (int k = 0; k < acc_n[i]; k++)
         if (acc_bits[i][k]) m_map[i] += (1 << k);
      m_cnt[i] = acc_n[i];
      m_rsn[i] = rsn;
      m_evt[i] = evt;
      m_vld[i] = 1'b1;
      acc_n[i] = 0;
   endfunction

   // one clock of the model, using the inputs present at the edge
   function automatic void m_step(int i);
      bit rdy;
      bit done;
      if (reset) begin
         m_clear(i);
         return;
      end
      rdy = !m_vld[i] || map_ready;
      if (m_vld[i] && map_ready) m_vld[i] = 1'b0;
      if (!rdy) return;
      done = 1'b0;
      if (itype_valid && (itype == 3'd4 || itype == 3'd5)) begin
         acc_bits[i][acc_n[i]] = (itype == 3'd4);
         acc_n[i]++;
         if (acc_n[i] == m_n[i]) begin
            m_emit(i, 0, 0);
            done = 1'b1;
         end
      end
      if (!done && itype_valid &&
          (itype == 3'd1 || itype == 3'd2 || itype == 3'd3 || itype == 3'd6)) begin
         m_emit(i, 1, int'(itype));
         done = 1'b1;
      end
      if (!done && flush && acc_n[i] > 0) m_emit(i, 2, 0);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_one(string nm, int i, logic rdy, logic vld, logic [31:0] map,
                            logic [31:0] cnt, logic [31:0] rsn, logic [31:0] evt);
      chk({nm, ".ready"}, 32'(rdy), 32'(!m_vld[i] || map_ready));
      chk({nm, ".valid"}, 32'(vld), 32'(m_vld[i]));
      if (m_vld[i] || reset) begin
         chk({nm, ".map"},   map, m_map[i]);
         chk({nm, ".count"}, cnt, m_cnt[i]);
         chk({nm, ".reason"}, rsn, m_rsn[i]);
         chk({nm, ".event"}, evt, m_evt[i]);
      end
   endtask

   task automatic check_all();
      check_one("u31", 0, bus31.itype_ready_o, bus31.map_valid_o, 32'(bus31.branch_map_o),
                32'(bus31.branch_count_o), 32'(bus31.reason_o), 32'(bus31.event_itype_o));
      check_one("u4", 1, bus4.itype_ready_o, bus4.map_valid_o, 32'(bus4.branch_map_o),
                32'(bus4.branch_count_o), 32'(bus4.reason_o), 32'(bus4.event_itype_o));
   endtask

   task automatic step();
      @(posedge clk);
      m_step(0);
      m_step(1);
      @(negedge clk);
      check_all();
   endtask

   task automatic drv(bit v, int t, bit f, bit r);
      itype_valid = v;
      itype       = 3'(t);
      flush       = f;
      map_ready   = r;
   endtask

   initial begin
      m_clear(0);
      m_clear(1);
      #1 check_all();
      chk("rst_ready", 32'(bus31.itype_ready_o), 32'd1);
      step();
      step();
      reset = 1'b0;

      // 5,4,4 then exception
      drv(1, 5, 0, 1); step();
      drv(1, 4, 0, 1); step();
      drv(1, 4, 0, 1); step();
      drv(1, 1, 0, 1); step();
      chk("t1_valid", 32'(bus31.map_valid_o), 32'd1);
      chk("t1_map",   32'(bus31.branch_map_o), 32'h6);
      chk("t1_count", 32'(bus31.branch_count_o), 32'd3);
      chk("t1_reason", 32'(bus31.reason_o), 32'd1);
      chk("t1_event", 32'(bus31.event_itype_o), 32'd1);
      drv(0, 0, 0, 1); step();
      chk("t1_valid_fall", 32'(bus31.map_valid_o), 32'd0);

      // 31 not-taken branches fill the map
      for (int k = 0; k < 31; k++) begin
         drv(1, 4, 0, 1); step();
      end
      chk("t2_valid", 32'(bus31.map_valid_o), 32'd1);
      chk("t2_map",   32'(bus31.branch_map_o), 32'h7FFF_FFFF);
      chk("t2_count", 32'(bus31.branch_count_o), 32'd31);
      chk("t2_reason", 32'(bus31.reason_o), 32'd0);
      drv(0, 0, 1, 1); step();
      chk("t2_acc_empty", 32'(bus31.map_valid_o), 32'd0);
      drv(0, 0, 0, 1); step();

      // backpressure holds the record and stalls the stream
      drv(1, 2, 0, 1); step();
      chk("t3_valid", 32'(bus31.map_valid_o), 32'd1);
      chk("t3_count", 32'(bus31.branch_count_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         drv(1, 5, 0, 0); step();
         chk("t3_ready_low", 32'(bus31.itype_ready_o), 32'd0);
         chk("t3_hold_event", 32'(bus31.event_itype_o), 32'd2);
      end
      drv(1, 5, 0, 1); step();
      chk("t3_accepted", 32'(bus31.map_valid_o), 32'd0);
      drv(1, 1, 0, 1); step();
      chk("t3_fresh_map", 32'(bus31.branch_map_o), 32'h0);
      chk("t3_fresh_count", 32'(bus31.branch_count_o), 32'd1);

      // flush with empty and with partial map
      drv(0, 0, 1, 1); step();
      chk("t4_no_record", 32'(bus31.map_valid_o), 32'd0);
      drv(1, 4, 0, 1); step();
      drv(1, 4, 0, 1); step();
      drv(0, 0, 1, 1); step();
      chk("t4_map",    32'(bus31.branch_map_o), 32'h3);
      chk("t4_count",  32'(bus31.branch_count_o), 32'd2);
      chk("t4_reason", 32'(bus31.reason_o), 32'd2);
      drv(0, 0, 0, 1); step();

      // small map: FULL beats flush, then back-to-back DISCON
      drv(1, 4, 0, 1); step();
      drv(1, 4, 0, 1); step();
      drv(1, 4, 0, 1); step();
      drv(1, 5, 1, 1); step();
      chk("t5_full_map",    32'(bus4.branch_map_o), 32'h7);
      chk("t5_full_count",  32'(bus4.branch_count_o), 32'd4);
      chk("t5_full_reason", 32'(bus4.reason_o), 32'd0);
      chk("t5_u31_flush",   32'(bus31.reason_o), 32'd2);
      drv(1, 1, 0, 1); step();
      chk("t5_dis_valid",  32'(bus4.map_valid_o), 32'd1);
      chk("t5_dis_count",  32'(bus4.branch_count_o), 32'd0);
      chk("t5_dis_reason", 32'(bus4.reason_o), 32'd1);
      chk("t5_dis_event",  32'(bus4.event_itype_o), 32'd1);
      drv(0, 0, 0, 1); step();

      // reset while a 5-branch record is pending
      for (int k = 0; k < 5; k++) begin
         drv(1, 4, 0, 1); step();
      end
      drv(1, 3, 0, 0); step();
      drv(0, 0, 0, 0); step();
      chk("t6_pending", 32'(bus31.branch_count_o), 32'd5);
      #2 reset = 1'b1;
      m_clear(0);
      m_clear(1);
      #1 check_all();
      chk("t6_rst_valid", 32'(bus31.map_valid_o), 32'd0);
      chk("t6_rst_count", 32'(bus31.branch_count_o), 32'd0);
      chk("t6_rst_ready", 32'(bus31.itype_ready_o), 32'd1);
      step();
      reset = 1'b0;
      drv(1, 1, 0, 1); step();
      chk("t6_after_valid", 32'(bus31.map_valid_o), 32'd1);
      chk("t6_after_count", 32'(bus31.branch_count_o), 32'd0);

      // randomized traffic, branch-heavy so both maps fill regularly
      for (int c = 0; c < 3000; c++) begin
         int t;
         t = ($urandom_range(0, 9) < 7) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 7));
         drv($urandom_range(0, 3) != 0, t, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_map_builder.md
Name: branch_map_builder

Overview:
- Sits downstream of the itype detector, on the encoder side of the CVA6 trace connector.
- Consumes the per-retirement itype stream and accumulates branch outcomes into an E-Trace branch map.
- Emits a map record when the map fills, when a discontinuity (exception, interrupt, eret, uninferable jump) retires, or on an explicit flush.
- Records go out through a valid/ready handshake to the packet emitter; the block backpressures the itype stream while a record is pending.

Parameters:
N_BRANCH, 31, branches per full map; legal range 1..31
CNT_W, $clog2(N_BRANCH+1), width of branch count (derived, not overridden)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
itype_valid_i  in  1  itype_i carries a retired-instruction type this cycle
itype_i  in  3  itype_e: 0 std, 1 exc, 2 int, 3 eret, 4 nontaken br, 5 taken br, 6 uninf jump, 7 reserved
itype_ready_o  out  1  block accepts itype_i this cycle
flush_i  in  1  request emission of partial map (e.g. trace stop/sync)
map_valid_o  out  1  output record valid
map_ready_i  in  1  emitter accepts record
branch_map_o  out  31  bit k = outcome of k-th branch in record; 1 = not taken, 0 = taken; bits >= count are 0
branch_count_o  out  CNT_W  number of valid bits in branch_map_o
reason_o  out  2  0 FULL, 1 DISCON, 2 FLUSH, 3 unused
event_itype_o  out  3  itype that caused DISCON; 0 for FULL/FLUSH

Behaviour:
- Reset (async, immediate): accumulator map = 0, count = 0. All outputs 0, except itype_ready_o = 1.
- Reset mid-handshake drops the pending record and the partial map; neither is emitted after reset.
- Handshakes:
  - itype_ready_o = !map_valid_o | map_ready_i (combinational). An input is consumed on itype_valid_i & itype_ready_o.
  - Record transfer happens on map_valid_o & map_ready_i. Output fields are held stable while map_valid_o=1 and map_ready_i=0.
- Consumed itype 4/5:
  - Write bit[count] (1 for 4, 0 for 5), then count+1.
  - If the new count == N_BRANCH, load the output register with the map including this bit, count=N_BRANCH, reason FULL.
  - Clear the accumulator in that same cycle.
- Consumed itype 1/2/3/6: load the output register with the current accumulator (count may be 0), reason DISCON, event_itype_o=itype_i. Clear the accumulator.
- Consumed itype 0/7: no effect.
- flush_i:
  - Sampled only when itype_ready_o=1.
  - Emits reason FLUSH if the accumulator count (after any branch consumed this cycle) is > 0; otherwise no record.
  - Ignored (not remembered) when itype_ready_o=0.
- Priority when simultaneous: FULL > DISCON > FLUSH. A branch completing the map together with flush_i gives one FULL record. flush_i together with a discontinuity gives one DISCON record.
- Latency: the record appears on map_valid_o the cycle after the triggering input is consumed (registered output).
- Back-to-back: if the record is accepted (map_ready_i=1) in the same cycle a new triggering input is consumed, the output register reloads with the new record and map_valid_o stays 1.
- If map_valid_o=1 and map_ready_i=0, no inputs are consumed and the accumulator is unchanged.
- map_valid_o falls the cycle after acceptance unless reloaded.
- Count never exceeds N_BRANCH; the accumulator is always cleared on emission.
- Two-state control: EMPTY (map_valid_o=0) and FULL_OUT (map_valid_o=1), with transitions as above.

Test Plan:
- Reset, then 3 valid itype 5,4,4, then itype 1 with map_ready_i=1 → one cycle later map_valid_o=1, branch_map_o=0b110, count=3, reason=1, event_itype_o=1; then map_valid_o=0.
- 31 consecutive itype 4 with map_ready_i=1 → single record: map=0x7FFFFFFF, count=31, reason=0; accumulator count back to 0.
- Hold map_ready_i=0 after a DISCON record, drive itype 5 for 4 cycles → itype_ready_o=0 throughout, record stable; release ready → record accepted, next itype 5 recorded as bit0=0 of a fresh map.
- flush_i with count=0 → no record. Two itype 4 then flush_i → map=0b11, count=2, reason=2.
- N_BRANCH=4: itype 4,4,4 then itype 5 with flush_i and itype 1 the next cycle → FULL record (map=0b0111, count=4), then DISCON record with count=0, event_itype_o=1, back-to-back with map_ready_i=1.
- Assert reset_i while map_valid_o=1 and count=5 → all outputs 0 immediately, itype_ready_o=1. After release, itype 1 yields a DISCON record with count=0.
